// File: rtl/debounce_pkg.sv
// Shared types and default constants for the button debounce controller and its prescaler.
package debounce_pkg;

   localparam int DEF_TICK_DIV   = 100000;
   localparam int DEF_STABLE_CNT = 4;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      WAIT_HIGH = 2'b01,
      IDLE_HIGH = 2'b10,
      WAIT_LOW  = 2'b11
   } state_t;

endpackage

// File: rtl/button_debounce_ctrl_if.sv
// Button-side signal bundle: raw input in, conditioned level, edge pulses, tick and busy out.
interface button_debounce_ctrl_if;

   logic btn_raw;
   logic btn_level;
   logic btn_rise;
   logic btn_fall;
   logic sample_tick;
   logic busy;

   // master drives the raw button and consumes the conditioned outputs
   modport master (
      output btn_raw,
      input  btn_level, btn_rise, btn_fall, sample_tick, busy
   );

   modport slave (
      input  btn_raw,
      output btn_level, btn_rise, btn_fall, sample_tick, busy
   );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: registered one-cycle tick every TICK_DIV clocks, first one TICK_DIV cycles after reset.
module tick_gen
   import debounce_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int            W    = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
   localparam logic [W-1:0] PRE  = W'(TICK_DIV - 2);

   logic [W-1:0] count;

   // tick is registered from PRE so it is high in exactly the cycle where count == LAST
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
         count <= (count == LAST) ? '0 : count + 1'b1;
         tick  <= (count == PRE);
      end
   end

endmodule

// File: rtl/button_debounce_ctrl.sv
// Push-button debouncer: tick-sampled four-state qualifier with registered level, edge pulses and busy.
// Define DEBOUNCE_SYNC_EN to insert a second synchronizer flop on btn_raw.
module button_debounce_ctrl
   import debounce_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int STABLE_CNT = DEF_STABLE_CNT
) (
   input logic                  clk,
   input logic                  reset,
   button_debounce_ctrl_if.slave bus
);

   localparam int             CW       = $clog2(STABLE_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

   logic          btn_s;
   logic          tick;
   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          level_q, rise_q, fall_q, busy_q;
   logic          level_d, rise_d, fall_d, busy_d;

`ifdef DEBOUNCE_SYNC_EN
   logic btn_meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         btn_meta <= bus.btn_raw;
         btn_s    <= btn_meta;
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) btn_s <= 1'b0;
      else        btn_s <= bus.btn_raw;
   end
`endif

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Output flops load from next-state decode so they change on the same edge as the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE_LOW;
         cnt     <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      // NOTE: defaulting every combinational output first rules out inferred latches on untaken branches.
      state_next = state;
      cnt_next   = cnt;
      if (tick) begin
         unique case (state)
            IDLE_LOW: if (btn_s) begin
               state_next = WAIT_HIGH;
               cnt_next   = CW'(1);
            end
            WAIT_HIGH: if (!btn_s) begin
               state_next = IDLE_LOW;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE_HIGH;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
            IDLE_HIGH: if (!btn_s) begin
               state_next = WAIT_LOW;
               cnt_next   = CW'(1);
            end
            WAIT_LOW: if (btn_s) begin
               state_next = IDLE_HIGH;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE_LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         endcase
      end
   end

   // Pulses fire only on the qualifying transition, never on an abort back to the old idle state.
   always_comb begin
      level_d = (state_next == IDLE_HIGH) || (state_next == WAIT_LOW);
      busy_d  = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
      rise_d  = (state == WAIT_HIGH) && (state_next == IDLE_HIGH);
      fall_d  = (state == WAIT_LOW)  && (state_next == IDLE_LOW);
   end

   assign bus.btn_level   = level_q;
   assign bus.btn_rise    = rise_q;
   assign bus.btn_fall    = fall_q;
   assign bus.busy        = busy_q;
   assign bus.sample_tick = tick;

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Directed + randomized bench for button_debounce_ctrl against a run-length reference model.
module tb_button_debounce_ctrl;

   localparam int TD = 4;
   localparam int SC = 3;

   logic  clk   = 1'b0;
   logic  reset = 1'b0;
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    rise_cnt = 0;
   int    fall_cnt = 0;
   int    tick_cnt = 0;
   string sect = "init";

   // Reference model: phase of the tick period, sampled input pipeline, accepted level,
   // and the length of the current run of ticks that disagree with the accepted level.
   int m_phase, m_run;
   bit m_tick, m_s, m_meta, m_level, m_rise, m_fall, m_busy;

   always #5 clk = ~clk;

   button_debounce_ctrl_if bus ();

   button_debounce_ctrl #(
      .TICK_DIV   (TD),
      .STABLE_CNT (SC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s @cycle %0d: observed %0d expected %0d", sect, tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_run   = 0;
      m_tick  = 1'b0;
      m_s     = 1'b0;
      m_meta  = 1'b0;
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_busy  = 1'b0;
   endtask

   // One clock edge: a tick that sees a value different from the accepted level extends the run,
   // a matching tick clears it, and a run of SC ticks flips the level and emits one edge pulse.
   task automatic model_edge(input bit raw);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_tick) begin
         if (m_s != m_level) begin
            m_run++;
            if (m_run == SC) begin
               m_level = !m_level;
               m_rise  = m_level;
               m_fall  = !m_level;
               m_run   = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      m_busy  = (m_run != 0);
      m_phase = (m_phase + 1) % TD;
      m_tick  = (m_phase == TD - 1);
`ifdef DEBOUNCE_SYNC_EN
      m_s    = m_meta;
      m_meta = raw;
`else
      m_s = raw;
`endif
   endtask

   task automatic check_outputs();
      check("btn_level",   bus.btn_level,   m_level);
      check("btn_rise",    bus.btn_rise,    m_rise);
      check("btn_fall",    bus.btn_fall,    m_fall);
      check("sample_tick", bus.sample_tick, m_tick);
      check("busy",        bus.busy,        m_busy);
      check("rise_and_fall", bus.btn_rise & bus.btn_fall, 1'b0);
      if (bus.btn_rise === 1'b1)    rise_cnt++;
      if (bus.btn_fall === 1'b1)    fall_cnt++;
      if (bus.sample_tick === 1'b1) tick_cnt++;
   endtask

   task automatic step(input bit raw);
      bus.btn_raw = raw;
      @(posedge clk);
      cyc++;
      model_edge(raw);
      #1;
      check_outputs();
   endtask

   task automatic hold(input bit raw, input int n);
      repeat (n) step(raw);
   endtask

   task automatic start_section(input string name);
      sect     = name;
      rise_cnt = 0;
      fall_cnt = 0;
      tick_cnt = 0;
   endtask

   initial begin
      bus.btn_raw = 1'b0;
      model_reset();

      start_section("reset");
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset = 1'b1;

      start_section("tick_cadence");
      hold(1'b0, 3 * TD);
      check("tick_count", tick_cnt, 3);

      start_section("bounce");
      hold(1'b1, TD);
      hold(1'b0, TD);
      hold(1'b1, TD);
      hold(1'b0, TD);
      hold(1'b0, 2 * TD);
      check("rise_count", rise_cnt, 0);
      check("level_low", bus.btn_level, 1'b0);

      start_section("clean_press");
      hold(1'b0, 1);
      hold(1'b1, (SC + 2) * TD);
      check("rise_count", rise_cnt, 1);
      check("level_high", bus.btn_level, 1'b1);
      check("busy_idle", bus.busy, 1'b0);

      start_section("release");
      hold(1'b0, 2 * TD);
      hold(1'b1, TD);
      check("fall_early", fall_cnt, 0);
      hold(1'b0, (SC + 2) * TD);
      check("fall_count", fall_cnt, 1);
      check("level_low", bus.btn_level, 1'b0);

      start_section("reset_mid_qual");
      hold(1'b1, 2 * TD);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (3) @(posedge clk);
      cyc += 3;
      #1;
      check_outputs();
      reset = 1'b1;
      hold(1'b1, SC * TD - 1);
      check("no_early_rise", rise_cnt, 0);
      hold(1'b1, 2 * TD);
      check("rise_after_reset", rise_cnt, 1);

      start_section("random");
      for (int k = 0; k < 60; k++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 5 * TD)));
      end
      hold(1'b0, (SC + 2) * TD);
      check("settled_low", bus.btn_level, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_debounce_ctrl.md
# button_debounce_ctrl

Push-button conditioning controller that sits in front of the sequence-detector FSMs (Moore and Mealy variants). It samples a raw, bouncing button input at a programmable tick rate, qualifies a level change only after a run of consecutive identical samples, and issues a clean debounced level, single-cycle edge pulses, and the sample strobe used as the detector's clock enable. It is the single sequencing point between the board button and every downstream detector.

## Interface
- TICK_DIV, 100000, clk cycles per sample tick; legal range ≥ 2.
- STABLE_CNT, 4, consecutive matching ticks needed to accept a level change; legal range ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_raw  input  1  raw button; asynchronous to clk and may bounce.
- btn_level  output  1  debounced button level.
- btn_rise  output  1  one-clk pulse on an accepted 0→1 change.
- btn_fall  output  1  one-clk pulse on an accepted 1→0 change.
- sample_tick  output  1  one-clk strobe every TICK_DIV cycles; also the detector enable.
- busy  output  1  high while a candidate change is being qualified.

## Operation
- Input path: btn_raw passes through one input flop to form btn_s. With DEBOUNCE_SYNC_EN defined, a second flop is added in series.
- Tick counter: counts 0..TICK_DIV-1 and wraps to 0. sample_tick is registered high for the single cycle when the count equals TICK_DIV-1.
- FSM states:
  - IDLE_LOW: stable low.
  - WAIT_HIGH: qualifying a rise.
  - IDLE_HIGH: stable high.
  - WAIT_LOW: qualifying a fall.
- The FSM and the run counter cnt advance only on cycles where sample_tick=1.
- IDLE_LOW:
  - btn_s=1 → WAIT_HIGH, cnt=1.
  - Otherwise stay.
- WAIT_HIGH:
  - btn_s=0 → IDLE_LOW, cnt=0.
  - btn_s=1 and cnt=STABLE_CNT-1 → IDLE_HIGH, cnt=0, btn_rise=1.
  - Otherwise cnt+1.
- IDLE_HIGH and WAIT_LOW mirror the rules above with the polarity inverted; their acceptance raises btn_fall.
- Net effect: a change is accepted only after STABLE_CNT consecutive ticks at the new value. A single mismatching tick aborts qualification and cnt restarts from 0.
- Width of cnt: $clog2(STABLE_CNT) bits; cnt never exceeds STABLE_CNT-1.
- btn_level = 1 in IDLE_HIGH and WAIT_LOW, and 0 otherwise.
- busy = 1 in WAIT_HIGH and WAIT_LOW.
- All outputs are registered. btn_rise and btn_fall are never high at the same time and never high for two consecutive cycles.

## Timing
- Reset (reset=0, asynchronous):
  - State = IDLE_LOW; cnt, tick counter and input flops = 0.
  - btn_level, btn_rise, btn_fall, sample_tick and busy all = 0.
- After reset release, the first sample_tick occurs TICK_DIV cycles later, then every TICK_DIV cycles.
- Input latency (btn_raw to btn_s): 1 cycle without DEBOUNCE_SYNC_EN, 2 cycles with it.
- btn_rise/btn_fall and the new btn_level update on the same clock edge: the edge that follows the accepting tick cycle.
- Minimum press-to-pulse delay: STABLE_CNT ticks plus the input latency.
- A btn_raw glitch between ticks is invisible.
- Reset asserted mid-qualification discards cnt. No pulse is emitted, during or after reset.

## Configuration
- DEBOUNCE_SYNC_EN defined: two-flop synchronizer on btn_raw, for metastability-safe use with a real board button. Input latency is 2 cycles.
- DEBOUNCE_SYNC_EN not defined: single input flop only, intended for simulation and synchronous sources. Input latency is 1 cycle.
- FSM behaviour is otherwise identical in both builds.

## Structure
- Shared package debounce_pkg holds:
  - the state typedef: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW, 2-bit encoded;
  - the default constants DEF_TICK_DIV=100000 and DEF_STABLE_CNT=4.
- The prescaler is the sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick). It is reused by other board-I/O blocks.
- The FSM, run counter and output registers stay in button_debounce_ctrl.

## Test plan
Use TICK_DIV=4, STABLE_CNT=3, with DEBOUNCE_SYNC_EN not defined unless stated.
- Tick cadence: release reset → sample_tick high in exactly cycles 4, 8, 12 after release; low in every other cycle.
- Clean press: btn_raw=1 held from cycle 2 → busy rises with tick 1. Three high ticks are required, so the third high tick is the accepting tick. The following edge gives one cycle of btn_rise=1 and btn_level=1; busy=0 afterwards.
- Bounce rejection: btn_raw toggled 1,0,1,0 on successive ticks → btn_level stays 0, no btn_rise, busy toggles and returns to 0.
- Release: from stable high, btn_raw=0 for 3 ticks → single btn_fall pulse, btn_level=0. One high tick mid-run restarts the count.
- Reset mid-qualification: btn_raw=1 for 2 ticks, then reset=0 for 3 cycles → all outputs 0 immediately. After release, no btn_rise until 3 fresh high ticks.
- Macro build: repeat the clean-press case with DEBOUNCE_SYNC_EN defined, with btn_raw raised in the cycle just before a tick → btn_rise occurs one tick period later than in the non-macro build, because the extra synchronizer flop makes that tick see the old value.
